branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- IF-stage branch predictor directly upstream of the instruction-fetch PC register; drives `branch_predict_pc` and `branch_taken` consumed by the IF unit.
- Direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters.
- Lookup is combinational on the current fetch PC.
- Table is trained by branch resolution from EX and cleared on request (fence.i / context flush).

Parameters:
- WIDTH, 32, address/data width.
- BTB_ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- IDX_W, $clog2(BTB_ENTRIES), index width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_pc  input  WIDTH  current fetch PC (the IF unit's pc_out).
- branch_predict_pc  output  WIDTH  predicted next PC.
- branch_taken  output  1  predicted taken.
- ex_br_valid  input  1  a branch/jump resolved in EX this cycle.
- ex_br_pc  input  WIDTH  PC of the resolved branch.
- ex_br_taken  input  1  actual direction.
- ex_br_target  input  WIDTH  actual target when taken.
- branch_miss  input  1  EX mispredict flag; used only by the counters under BP_PERF_CNT_EN.
- bp_clear  input  1  invalidate the whole table.

Behaviour:
- Entry fields: valid, tag[WIDTH-IDX_W-3:0], target[WIDTH-1:0], cnt[1:0].
- Index = pc[IDX_W+1:2]. Tag = pc[WIDTH-1:IDX_W+2]. pc[1:0] ignored.
- Lookup (combinational, zero latency): hit = valid[idx] & (tag == fetch_pc tag).
  - branch_taken = hit & cnt[1].
  - branch_predict_pc = branch_taken ? target : fetch_pc + 4, modulo 2^WIDTH (0xFFFFFFFC -> 0x00000000).
- Update on a clock edge when ex_br_valid = 1 and bp_clear = 0, using the index/tag of ex_br_pc:
  - Hit, taken: cnt saturating increment (max 2'b11); target <= ex_br_target.
  - Hit, not taken: cnt saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate/overwrite. valid <= 1, tag, target <= ex_br_target, cnt <= 2'b10.
  - Miss, not taken: no change.
- bp_clear = 1:
  - Next edge: all valid <= 0 and all cnt <= 2'b01; targets/tags untouched.
  - Takes priority over a simultaneous ex_br_valid update, which is dropped.
- Write/read collision: lookup and update to the same index in the same cycle.
  - Lookup returns the pre-update entry (no bypass).
  - The new value is visible the cycle after the edge.
- No stall or flush inputs: the table is never modified by stall/flush, only by ex_br_valid and bp_clear.
- Reset (asynchronous, any time including mid-update):
  - All valid = 0, cnt = 2'b01, tag = 0, target = 0.
  - Outputs are therefore branch_taken = 0, branch_predict_pc = fetch_pc + 4 (4 when fetch_pc = 0).
  - A pending update on the reset edge is lost.
- Outputs must be free of X whenever fetch_pc is known, including immediately after reset.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_br_cnt (WIDTH) and perf_miss_cnt (WIDTH).
  - perf_br_cnt increments on each edge with ex_br_valid = 1.
  - perf_miss_cnt increments on each edge with ex_br_valid = 1 and branch_miss = 1.
  - Both count regardless of bp_clear.
  - Both wrap from 2^WIDTH-1 to 0.
  - Both reset to 0 by rst_n only.
- Undefined:
  - Ports and counters are absent.
  - branch_miss is unused.
  - Table behaviour is identical.

Test Plan:
- Reset, then fetch_pc = 0x00000100 -> branch_taken = 0, branch_predict_pc = 0x00000104; fetch_pc = 0xFFFFFFFC -> predict 0x00000000.
- Allocate:
  - Update ex_br_pc = 0x40, taken, target 0x80 -> next cycle fetch_pc = 0x40 gives taken = 1, predict 0x80.
  - fetch_pc = 0x80 (same index 0 for 16 entries, different tag) -> taken = 0, predict 0x84.
- Counter saturation, starting from the 0x40 entry at cnt 2'b10:
  - Two taken updates -> cnt 2'b11, still taken.
  - Two not-taken updates -> cnt 2'b01, fetch 0x40 predicts 0x44.
  - Two more not-taken -> cnt 2'b00, held.
  - One taken -> 2'b01, not taken.
  - Second taken -> 2'b10, taken to the latest target.
- Collision: fetch_pc = 0x40 while updating 0x40 taken target 0x90 in the same cycle -> that cycle shows the old prediction; next cycle predicts 0x90.
- bp_clear asserted together with ex_br_valid (0x200, taken, 0x300) -> next cycle both 0x40 and 0x200 predict not taken, pc+4.
- Perf counters (BP_PERF_CNT_EN): 5 resolved branches, 2 with branch_miss = 1 -> perf_br_cnt = 5, perf_miss_cnt = 2. Async reset mid-sequence -> both 0 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit saturating counters and combinational lookup.
// Optional performance counters are enabled with `define BP_PERF_CNT_EN.
module branch_predictor #(
    parameter int WIDTH       = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fetch_pc,
    output logic [WIDTH-1:0] branch_predict_pc,
    output logic             branch_taken,
    input  logic             ex_br_valid,
    input  logic [WIDTH-1:0] ex_br_pc,
    input  logic             ex_br_taken,
    input  logic [WIDTH-1:0] ex_br_target,
    input  logic             branch_miss,
`ifdef BP_PERF_CNT_EN
    output logic [WIDTH-1:0] perf_br_cnt,
    output logic [WIDTH-1:0] perf_miss_cnt,
`endif
    input  logic             bp_clear
);

    localparam int TAG_W = WIDTH - IDX_W - 2;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic [BTB_ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]       tag_r    [BTB_ENTRIES];
    logic [WIDTH-1:0]       target_r [BTB_ENTRIES];
    logic [1:0]             cnt_r    [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx_s;
    logic [TAG_W-1:0] rd_tag_s;
    logic             rd_hit_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [TAG_W-1:0] wr_tag_s;
    logic             wr_hit_s;

    assign rd_idx_s = fetch_pc[IDX_W+1:2];
    assign rd_tag_s = fetch_pc[WIDTH-1:IDX_W+2];
    assign wr_idx_s = ex_br_pc[IDX_W+1:2];
    assign wr_tag_s = ex_br_pc[WIDTH-1:IDX_W+2];
    assign wr_hit_s = valid_r[wr_idx_s] && (tag_r[wr_idx_s] == wr_tag_s);

    // Zero-latency lookup; reads pre-update state, so a same-cycle write is not bypassed.
    always_comb begin
        rd_hit_s          = 1'b0;
        branch_taken      = 1'b0;
        branch_predict_pc = fetch_pc + {{(WIDTH-3){1'b0}}, 3'b100};
        rd_hit_s          = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
        if (rd_hit_s && cnt_r[rd_idx_s][1]) begin
            branch_taken      = 1'b1;
            branch_predict_pc = target_r[rd_idx_s];
        end else begin
            branch_taken      = 1'b0;
        end
    end

    // Table state: clear beats training; training only touches the indexed entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {BTB_ENTRIES{1'b0}};
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {WIDTH{1'b0}};
                cnt_r[i]    <= 2'b01;
            end
        end else if (bp_clear) begin
            valid_r <= {BTB_ENTRIES{1'b0}};
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                cnt_r[i] <= 2'b01;
            end
        end else if (ex_br_valid) begin
            if (wr_hit_s) begin
                if (ex_br_taken) begin
                    cnt_r[wr_idx_s]    <= sat_inc(cnt_r[wr_idx_s]);
                    target_r[wr_idx_s] <= ex_br_target;
                end else begin
                    cnt_r[wr_idx_s]    <= sat_dec(cnt_r[wr_idx_s]);
                end
            end else if (ex_br_taken) begin
                valid_r[wr_idx_s]  <= 1'b1;
                tag_r[wr_idx_s]    <= wr_tag_s;
                target_r[wr_idx_s] <= ex_br_target;
                cnt_r[wr_idx_s]    <= 2'b10;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    // Event counters follow EX resolutions only and ignore bp_clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_cnt   <= {WIDTH{1'b0}};
            perf_miss_cnt <= {WIDTH{1'b0}};
        end else if (ex_br_valid) begin
            perf_br_cnt <= perf_br_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
            if (branch_miss) begin
                perf_miss_cnt <= perf_miss_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    logic unused_miss_s;
    assign unused_miss_s = branch_miss;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (perf counters checked when BP_PERF_CNT_EN is defined).
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic [31:0] branch_predict_pc;
    logic        branch_taken;
    logic        ex_br_valid;
    logic [31:0] ex_br_pc;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic        branch_miss;
    logic        bp_clear;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_miss_cnt;
`endif

    int checks_r;
    int failures_r;

    branch_predictor #(.WIDTH(32), .BTB_ENTRIES(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_pc          (fetch_pc),
        .branch_predict_pc (branch_predict_pc),
        .branch_taken      (branch_taken),
        .ex_br_valid       (ex_br_valid),
        .ex_br_pc          (ex_br_pc),
        .ex_br_taken       (ex_br_taken),
        .ex_br_target      (ex_br_target),
        .branch_miss       (branch_miss),
`ifdef BP_PERF_CNT_EN
        .perf_br_cnt       (perf_br_cnt),
        .perf_miss_cnt     (perf_miss_cnt),
`endif
        .bp_clear          (bp_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic predict(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] npc);
        fetch_pc = pc;
        #1;
        check_val({tag, "_taken"}, {31'd0, branch_taken}, {31'd0, tk});
        check_val({tag, "_pc"}, branch_predict_pc, npc);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic miss);
        @(negedge clk);
        ex_br_valid  = 1'b1;
        ex_br_pc     = pc;
        ex_br_taken  = tk;
        ex_br_target = tgt;
        branch_miss  = miss;
        @(posedge clk);
        #1;
        ex_br_valid  = 1'b0;
        branch_miss  = 1'b0;
    endtask

    initial begin
        checks_r     = 0;
        failures_r   = 0;
        rst_n        = 1'b0;
        fetch_pc     = 32'h0000_0100;
        ex_br_valid  = 1'b0;
        ex_br_pc     = 32'h0;
        ex_br_taken  = 1'b0;
        ex_br_target = 32'h0;
        branch_miss  = 1'b0;
        bp_clear     = 1'b0;

        predict("rst_100", 32'h0000_0100, 1'b0, 32'h0000_0104);
        predict("rst_0", 32'h0000_0000, 1'b0, 32'h0000_0004);
        predict("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        predict("post_rst", 32'h0000_0040, 1'b0, 32'h0000_0044);

        // Allocate at index 0, then alias with a different tag.
        upd(32'h0000_0040, 1'b1, 32'h0000_0080, 1'b0);
        predict("alloc", 32'h0000_0040, 1'b1, 32'h0000_0080);
        predict("alias", 32'h0000_0080, 1'b0, 32'h0000_0084);
        upd(32'h0000_003C, 1'b1, 32'h0000_1000, 1'b0);
        predict("idx15", 32'h0000_003C, 1'b1, 32'h0000_1000);

        // Saturation walk from cnt=10.
        upd(32'h0000_0040, 1'b1, 32'h0000_0080, 1'b0);
        upd(32'h0000_0040, 1'b1, 32'h0000_0080, 1'b0);
        predict("sat11", 32'h0000_0040, 1'b1, 32'h0000_0080);
        upd(32'h0000_0040, 1'b0, 32'h0000_0000, 1'b1);
        predict("dec10", 32'h0000_0040, 1'b1, 32'h0000_0080);
        upd(32'h0000_0040, 1'b0, 32'h0000_0000, 1'b1);
        predict("dec01", 32'h0000_0040, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b0, 32'h0000_0000, 1'b0);
        upd(32'h0000_0040, 1'b0, 32'h0000_0000, 1'b0);
        predict("sat00", 32'h0000_0040, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b1, 32'h0000_00A0, 1'b1);
        predict("inc01", 32'h0000_0040, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b1, 32'h0000_00B0, 1'b1);
        predict("inc10", 32'h0000_0040, 1'b1, 32'h0000_00B0);

        // Same-cycle lookup and update: old entry first, new one after the edge.
        @(negedge clk);
        fetch_pc     = 32'h0000_0040;
        ex_br_valid  = 1'b1;
        ex_br_pc     = 32'h0000_0040;
        ex_br_taken  = 1'b1;
        ex_br_target = 32'h0000_0090;
        #1;
        check_val("coll_old", branch_predict_pc, 32'h0000_00B0);
        @(posedge clk);
        #1;
        ex_br_valid = 1'b0;
        check_val("coll_new", branch_predict_pc, 32'h0000_0090);

        // Not-taken miss on an aliasing tag leaves the entry alone.
        upd(32'h0000_0080, 1'b0, 32'h0000_0000, 1'b0);
        predict("nt_miss", 32'h0000_0040, 1'b1, 32'h0000_0090);

        // Clear wins over a simultaneous allocation.
        @(negedge clk);
        bp_clear = 1'b1;
        upd(32'h0000_0200, 1'b1, 32'h0000_0300, 1'b0);
        bp_clear = 1'b0;
        predict("clr_40", 32'h0000_0040, 1'b0, 32'h0000_0044);
        predict("clr_200", 32'h0000_0200, 1'b0, 32'h0000_0204);
        predict("clr_3c", 32'h0000_003C, 1'b0, 32'h0000_0040);

        upd(32'h0000_0040, 1'b1, 32'h0000_0050, 1'b0);
        predict("realloc", 32'h0000_0040, 1'b1, 32'h0000_0050);

`ifdef BP_PERF_CNT_EN
        // Restart counters from zero, then 5 resolutions with 2 misses.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        upd(32'h0000_0040, 1'b1, 32'h0000_0050, 1'b1);
        upd(32'h0000_0044, 1'b0, 32'h0000_0000, 1'b0);
        @(negedge clk);
        bp_clear = 1'b1;
        upd(32'h0000_0048, 1'b1, 32'h0000_0060, 1'b1);
        bp_clear = 1'b0;
        upd(32'h0000_004C, 1'b0, 32'h0000_0000, 1'b0);
        upd(32'h0000_0050, 1'b1, 32'h0000_0070, 1'b0);
        check_val("perf_br", perf_br_cnt, 32'd5);
        check_val("perf_miss", perf_miss_cnt, 32'd2);
`endif

        // Asynchronous reset between edges takes effect immediately.
        upd(32'h0000_0040, 1'b1, 32'h0000_0050, 1'b0);
        predict("pre_arst", 32'h0000_0040, 1'b1, 32'h0000_0050);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_taken", {31'd0, branch_taken}, 32'd0);
        check_val("arst_pc", branch_predict_pc, 32'h0000_0044);
`ifdef BP_PERF_CNT_EN
        check_val("arst_perf_br", perf_br_cnt, 32'd0);
        check_val("arst_perf_miss", perf_miss_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        predict("post_arst", 32'h0000_0040, 1'b0, 32'h0000_0044);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
